// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use freeze, multi-cycle mul/div hold, taken-branch flush.
// Optional build macro STALL_STATS_EN adds a saturating stallCycles counter output.
module hazard_stall_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MD_LATENCY        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IFID_rs,
    input  logic [4:0] IFID_rt,
    input  logic       ID_usesRt,
    input  logic [4:0] IDEX_rt,
    input  logic       IDEX_MemRead,
    input  logic       IDEX_mdStart,
    input  logic       EX_branchTaken,
    output logic       PCWrite,
    output logic       IFIDWrite,
    output logic       IFID_flush,
    output logic       IDEX_bubble,
    output logic       IDEX_hold,
    output logic       EXMEM_bubble,
    output logic       mdDone
`ifdef STALL_STATS_EN
    ,
    output logic [15:0] stallCycles
`endif
);

    typedef enum logic [1:0] {RUN, LOAD_STALL, MD_BUSY} state_t;

    // Counters hold "remaining cycles after this one", hence the -2 on entry.
    localparam logic [3:0] MD_INIT = 4'(MD_LATENCY - 2);
    localparam logic [3:0] LS_INIT = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       loadUse;

    assign loadUse = IDEX_MemRead && (IDEX_rt != 5'd0) &&
                     ((IDEX_rt == IFID_rs) || (ID_usesRt && (IDEX_rt == IFID_rt)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IFID_flush   = 1'b0;
        IDEX_bubble  = 1'b0;
        IDEX_hold    = 1'b0;
        EXMEM_bubble = 1'b0;
        mdDone       = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (EX_branchTaken) begin
                        IFID_flush  = 1'b1;
                        IDEX_bubble = 1'b1;
                    end else if (IDEX_mdStart) begin
                        PCWrite      = 1'b0;
                        IFIDWrite    = 1'b0;
                        IDEX_hold    = 1'b1;
                        EXMEM_bubble = 1'b1;
                        cnt_d        = MD_INIT;
                        state_d      = MD_BUSY;
                    end else if (loadUse) begin
                        PCWrite     = 1'b0;
                        IFIDWrite   = 1'b0;
                        IDEX_bubble = 1'b1;
                        // A single-cycle stall needs no state: the bubble clears the load from EX.
                        if (LOAD_STALL_CYCLES > 1) begin
                            cnt_d   = LS_INIT;
                            state_d = LOAD_STALL;
                        end
                    end
                end
                LOAD_STALL: begin
                    PCWrite     = 1'b0;
                    IFIDWrite   = 1'b0;
                    IDEX_bubble = 1'b1;
                    if (cnt_q == 4'd0) state_d = RUN;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                MD_BUSY: begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    if (cnt_q == 4'd0) begin
                        mdDone  = 1'b1;
                        state_d = RUN;
                    end else begin
                        IDEX_hold    = 1'b1;
                        EXMEM_bubble = 1'b1;
                        cnt_d        = cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef STALL_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!PCWrite && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_q <= 16'd0;
        else       stall_q <= stall_d;
    end

    assign stallCycles = stall_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (1-cycle and 3-cycle load stall),
// vector table, hand sequences and random stimulus against a freeze-countdown model.
module tb_hazard_stall_controller;

    localparam int LSC0 = 1, MDL0 = 4;
    localparam int LSC1 = 3, MDL1 = 5;

    // Packed view {PCWrite, IFIDWrite, IFID_flush, IDEX_bubble, IDEX_hold, EXMEM_bubble, mdDone}
    localparam logic [6:0] IDLE  = 7'b1100000;
    localparam logic [6:0] STALL = 7'b0001000;
    localparam logic [6:0] FLUSH = 7'b1111000;
    localparam logic [6:0] HOLD  = 7'b0000110;
    localparam logic [6:0] DONE  = 7'b0000001;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, ID_usesRt, IDEX_MemRead, IDEX_mdStart, EX_branchTaken;
    logic [4:0] IFID_rs, IFID_rt, IDEX_rt;
    logic       pc0, ifw0, fl0, bb0, hd0, eb0, md0;
    logic       pc1, ifw1, fl1, bb1, hd1, eb1, md1;
`ifdef STALL_STATS_EN
    logic [15:0] sc0, sc1;
`endif

    hazard_stall_controller #(.LOAD_STALL_CYCLES(LSC0), .MD_LATENCY(MDL0)) u0 (
        .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .ID_usesRt(ID_usesRt),
        .IDEX_rt(IDEX_rt), .IDEX_MemRead(IDEX_MemRead), .IDEX_mdStart(IDEX_mdStart),
        .EX_branchTaken(EX_branchTaken), .PCWrite(pc0), .IFIDWrite(ifw0), .IFID_flush(fl0),
        .IDEX_bubble(bb0), .IDEX_hold(hd0), .EXMEM_bubble(eb0), .mdDone(md0)
`ifdef STALL_STATS_EN
        , .stallCycles(sc0)
`endif
    );

    hazard_stall_controller #(.LOAD_STALL_CYCLES(LSC1), .MD_LATENCY(MDL1)) u1 (
        .clk(clk), .reset(reset), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .ID_usesRt(ID_usesRt),
        .IDEX_rt(IDEX_rt), .IDEX_MemRead(IDEX_MemRead), .IDEX_mdStart(IDEX_mdStart),
        .EX_branchTaken(EX_branchTaken), .PCWrite(pc1), .IFIDWrite(ifw1), .IFID_flush(fl1),
        .IDEX_bubble(bb1), .IDEX_hold(hd1), .EXMEM_bubble(eb1), .mdDone(md1)
`ifdef STALL_STATS_EN
        , .stallCycles(sc1)
`endif
    );

    logic [6:0] got0, got1;
    assign got0 = {pc0, ifw0, fl0, bb0, hd0, eb0, md0};
    assign got1 = {pc1, ifw1, fl1, bb1, hd1, eb1, md1};

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: a frozen pipeline is just "cycles of freeze left" and what caused it.
    int rem[2], knd[2], stats[2], lsc[2], mdl[2];

    function automatic logic [6:0] mexp(input int i);
        logic lu;
        lu = IDEX_MemRead && IDEX_rt != 0 &&
             (IDEX_rt == IFID_rs || (ID_usesRt && IDEX_rt == IFID_rt));
        if (reset) return IDLE;
        if (rem[i] > 0) return (knd[i] == 1) ? STALL : ((rem[i] == 1) ? DONE : HOLD);
        if (EX_branchTaken) return FLUSH;
        if (IDEX_mdStart) return HOLD;
        if (lu) return STALL;
        return IDLE;
    endfunction

    task automatic mupd(input int i);
        logic [6:0] e;
        e = mexp(i);
        if (reset) begin
            rem[i] = 0; stats[i] = 0;
        end else begin
            if (!e[6] && stats[i] < 65535) stats[i]++;
            if (rem[i] > 0) rem[i]--;
            else if (!EX_branchTaken && IDEX_mdStart) begin rem[i] = mdl[i] - 1; knd[i] = 2; end
            else if (!EX_branchTaken && e == STALL) begin rem[i] = lsc[i] - 1; knd[i] = 1; end
        end
    endtask

    task automatic cyc(input string nm, input logic c0, input logic [6:0] e0,
                       input logic c1, input logic [6:0] e1);
        @(negedge clk);
        chk("model0", {9'd0, got0}, {9'd0, mexp(0)});
        chk("model1", {9'd0, got1}, {9'd0, mexp(1)});
`ifdef STALL_STATS_EN
        chk("stats0", sc0, 16'(stats[0]));
        chk("stats1", sc1, 16'(stats[1]));
`endif
        if (c0) chk({nm, "_u0"}, {9'd0, got0}, {9'd0, e0});
        if (c1) chk({nm, "_u1"}, {9'd0, got1}, {9'd0, e1});
        @(posedge clk);
        mupd(0);
        mupd(1);
        #1;
    endtask

    task automatic run();
        cyc("", 1'b0, 7'd0, 1'b0, 7'd0);
    endtask

    task automatic setin(input logic r, input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic u, input logic md, input logic br);
        reset = r; IDEX_MemRead = mr; IDEX_rt = xrt; IFID_rs = rs; IFID_rt = rt;
        ID_usesRt = u; IDEX_mdStart = md; EX_branchTaken = br;
    endtask

    typedef struct {
        logic       r, mr;
        logic [4:0] xrt, rs, rt;
        logic       u, md, br;
        logic [6:0] e;
    } vec_t;

    vec_t tbl[10];

    initial begin
        lsc[0] = LSC0; mdl[0] = MDL0; lsc[1] = LSC1; mdl[1] = MDL1;
        rem = '{0, 0}; knd = '{0, 0}; stats = '{0, 0};
        setin(1, 0, 0, 0, 0, 0, 0, 0);

        tbl[0] = '{1, 1, 5, 5, 0, 0, 0, 0, IDLE};   // reset forces idle
        tbl[1] = '{0, 1, 5, 5, 0, 0, 0, 0, STALL};  // rs hit
        tbl[2] = '{0, 1, 5, 3, 5, 0, 0, 0, IDLE};   // rt hit, rt unused
        tbl[3] = '{0, 1, 5, 3, 5, 1, 0, 0, STALL};  // rt hit, rt used
        tbl[4] = '{0, 1, 0, 0, 0, 1, 0, 0, IDLE};   // $0 never stalls
        tbl[5] = '{0, 0, 5, 5, 5, 1, 0, 0, IDLE};   // not a load
        tbl[6] = '{0, 1, 5, 5, 0, 0, 0, 1, FLUSH};  // branch beats load-use
        tbl[7] = '{0, 0, 0, 0, 0, 0, 1, 0, HOLD};   // mul/div start
        tbl[8] = '{0, 0, 0, 0, 0, 0, 1, 1, FLUSH};  // branch beats mul/div
        tbl[9] = '{0, 1, 7, 7, 0, 0, 1, 0, HOLD};   // mul/div beats load-use

        for (int k = 0; k < 10; k++) begin
            setin(1, 0, 0, 0, 0, 0, 0, 0);
            run();
            setin(tbl[k].r, tbl[k].mr, tbl[k].xrt, tbl[k].rs, tbl[k].rt, tbl[k].u, tbl[k].md, tbl[k].br);
            cyc($sformatf("vec%0d", k), 1'b1, tbl[k].e, 1'b1, tbl[k].e);
        end

        // Load-use freeze length: 1 cycle vs 3 cycles
        setin(1, 0, 0, 0, 0, 0, 0, 0); run();
        setin(0, 1, 5, 5, 0, 0, 0, 0); cyc("lu_c1", 1, STALL, 1, STALL);
        setin(0, 0, 5, 5, 0, 0, 0, 0); cyc("lu_c2", 1, IDLE, 1, STALL);
        cyc("lu_c3", 1, IDLE, 1, STALL);
        cyc("lu_c4", 1, IDLE, 1, IDLE);

        // Mul/div occupancy, branch ignored while busy
        setin(1, 0, 0, 0, 0, 0, 0, 0); run();
        setin(0, 0, 0, 0, 0, 0, 1, 0); cyc("md_c1", 1, HOLD, 1, HOLD);
        setin(0, 0, 0, 0, 0, 0, 0, 1); cyc("md_c2", 1, HOLD, 1, HOLD);
        setin(0, 0, 0, 0, 0, 0, 0, 0); cyc("md_c3", 1, HOLD, 1, HOLD);
        cyc("md_c4", 1, DONE, 1, HOLD);
        cyc("md_c5", 1, IDLE, 1, DONE);
        cyc("md_c6", 1, IDLE, 1, IDLE);

        // Reset in the second MD_BUSY cycle aborts without mdDone
        setin(1, 0, 0, 0, 0, 0, 0, 0); run();
        setin(0, 0, 0, 0, 0, 0, 1, 0); cyc("mdr_c1", 1, HOLD, 1, HOLD);
        setin(0, 0, 0, 0, 0, 0, 0, 0); cyc("mdr_c2", 1, HOLD, 1, HOLD);
        setin(1, 0, 0, 0, 0, 0, 0, 0); cyc("mdr_rst", 1, IDLE, 1, IDLE);
        setin(0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc("mdr_after", 1, IDLE, 1, IDLE);

        // Random traffic; small register range to provoke hits
        for (int k = 0; k < 1500; k++) begin
            setin($urandom_range(49) == 0, $urandom_range(1), 5'($urandom_range(3)),
                  5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1),
                  $urandom_range(9) == 0, $urandom_range(9) == 0);
            run();
        end

`ifdef STALL_STATS_EN
        setin(1, 0, 0, 0, 0, 0, 0, 0); run();
        for (int n = 0; n < 2; n++) begin
            setin(0, 1, 5, 5, 0, 0, 0, 0); run();
            setin(0, 0, 0, 0, 0, 0, 0, 0); run(); run(); run();
        end
        chk("stats_two_events", sc1, 16'd6);

        setin(1, 0, 0, 0, 0, 0, 0, 0); run();
        setin(0, 1, 5, 5, 0, 0, 0, 0);
        repeat (65534) run();
        chk("stats_fffe", sc1, 16'hFFFE);
        repeat (3) run();
        chk("stats_sat", sc1, 16'hFFFF);
        chk("stats_sat0", sc0, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
